// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : data bits per frame (fixed at 8)
//   PAR_EVEN / PAR_ODD : parity type encoding, identical to the Tx side
//   parity_bit(): parity bit a transmitter appends for a given byte/type
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Even parity: bit makes the total count of ones even. Odd flips it.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] b,
                                      input logic p_type);
    return (^b) ^ (p_type == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_parity_parity_chk.sv
// Combinational parity checker; uses the same equation as the Tx parity
// generator so both directions share one convention.
//   i_byte   : received data byte
//   i_rx_par : received parity bit
//   i_p_type : parity type (0 even, 1 odd)
//   o_err    : 1 when the received parity bit is not the expected one
module parity_chk
  import uart_pkg::*;
(
  input  logic [DATA_BITS-1:0] i_byte,
  input  logic                 i_rx_par,
  input  logic                 i_p_type,
  output logic                 o_err
);

  assign o_err = i_rx_par ^ parity_bit(i_byte, i_p_type);

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop bit.
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   p_type     : parity type (0 even, 1 odd), latched at start of frame
//   data       : last received byte (held until next strobe)
//   data_valid : one-cycle strobe qualifying data and the error flags
//   parity_err : received parity mismatched expected parity
//   frame_err  : stop bit sampled low
//   busy       : FSM not in IDLE
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  input  logic                 p_type,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_rx_par;
  logic                 r_p_type_q;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 w_tick;
  logic                 w_par_err;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // w_tick marks a sample point: mid start bit, then every full bit period.
  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) w_state_next = START;
      end
      START: begin
        w_tick = (r_cnt == CNT_HALF);
        if (w_tick) w_state_next = r_rx_s ? IDLE : DATA;
      end
      DATA: begin
        w_tick = (r_cnt == CNT_FULL);
        if (w_tick && r_idx == IDX_LAST) w_state_next = PARITY;
      end
      PARITY: begin
        w_tick = (r_cnt == CNT_FULL);
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        w_tick = (r_cnt == CNT_FULL);
        if (w_tick) w_state_next = r_rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        if (r_rx_s) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  parity_chk u_parity_chk (
    .i_byte   (r_shift),
    .i_rx_par (r_rx_par),
    .i_p_type (r_p_type_q),
    .o_err    (w_par_err)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_rx_par     <= 1'b0;
      r_p_type_q   <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;

      // Counter restarts at every sample point and while waiting on the line.
      if (r_state == IDLE || r_state == BREAK || w_tick) r_cnt <= '0;
      else                                               r_cnt <= r_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (!r_rx_s) r_p_type_q <= p_type;
        end
        START: begin
          if (w_tick) r_idx <= '0;
        end
        DATA: begin
          if (w_tick) begin
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 1'b1;
          end
        end
        PARITY: begin
          if (w_tick) r_rx_par <= r_rx_s;
        end
        STOP: begin
          // Results land together with the return to IDLE, so a start bit
          // right after the stop bit is not missed.
          if (w_tick) begin
            r_data       <= r_shift;
            r_parity_err <= w_par_err;
            r_frame_err  <= ~r_rx_s;
            r_data_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
module tb_uart_rx_parity;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       p_type = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int t_fall;
  int base;

  logic [7:0] cap_data [0:31];
  logic       cap_pe   [0:31];
  logic       cap_fe   [0:31];
  int         cap_cyc  [0:31];

  uart_rx_parity #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .p_type     (p_type),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      cap_data[strobe_cnt[4:0]] <= data;
      cap_pe[strobe_cnt[4:0]]   <= parity_err;
      cap_fe[strobe_cnt[4:0]]   <= frame_err;
      cap_cyc[strobe_cnt[4:0]]  <= cyc;
      strobe_cnt                <= strobe_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_cycles(CPB);
  endtask

  // Bench Tx model: start, 8 data LSB first, parity, stop. Optionally flips
  // p_type halfway through the data bits.
  task automatic send_frame(input logic [7:0] b, input logic pbit,
                            input logic sbit, input logic flip);
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (flip && i == 4) p_type = ~p_type;
      send_bit(b[i]);
    end
    send_bit(pbit);
    send_bit(sbit);
  endtask

  task automatic check_strobe(input string tag, input int idx, input logic [7:0] d,
                              input logic pe, input logic fe);
    check({tag, "_data"}, 32'(cap_data[idx]), 32'(d));
    check({tag, "_perr"}, 32'(cap_pe[idx]), 32'(pe));
    check({tag, "_ferr"}, 32'(cap_fe[idx]), 32'(fe));
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    wait_cycles(4);
    resetn = 1'b1;
    wait_cycles(4);

    // Even parity, good frame; check latency from rx fall to strobe
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    wait_cycles(2);
    check("even_strobes", 32'(strobe_cnt), 32'd1);
    check_strobe("even", 0, 8'hA5, 1'b0, 1'b0);
    check("even_latency", 32'(cap_cyc[0] - t_fall), 32'd171);
    check("even_busy", 32'(busy), 32'h0);

    // Parity error: wrong parity bit for even
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_cycles(2);
    check("perr_strobes", 32'(strobe_cnt), 32'd2);
    check_strobe("perr", 1, 8'hA5, 1'b1, 1'b0);
    wait_cycles(20);
    check("perr_hold", 32'(parity_err), 32'h1);

    // Odd parity, p_type toggled mid-frame has no effect
    p_type = 1'b1;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    wait_cycles(2);
    check("odd_ptype_now", 32'(p_type), 32'h0);
    check("odd_strobes", 32'(strobe_cnt), 32'd3);
    check_strobe("odd", 2, 8'h01, 1'b0, 1'b0);
    p_type = 1'b0;

    // False start: 4-cycle low pulse
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    check("glitch_busy_hi", 32'(busy), 32'h1);
    for (int i = 0; i < 10 && busy; i++) wait_cycles(1);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    wait_cycles(20);
    check("glitch_strobes", 32'(strobe_cnt), 32'd3);

    // Framing error then break held for 40 bit times
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cycles(40 * CPB);
    check("break_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_cycles(6);
    check("break_strobes", 32'(strobe_cnt), 32'd4);
    check_strobe("ferr", 3, 8'h3C, 1'b0, 1'b1);
    check("break_idle", 32'(busy), 32'h0);
    wait_cycles(10);

    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    wait_cycles(2);
    check("after_brk_strobes", 32'(strobe_cnt), 32'd5);
    check_strobe("after_brk", 4, 8'h55, 1'b0, 1'b0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    wait_cycles(2);
    check("b2b_strobes", 32'(strobe_cnt), 32'd8);
    check_strobe("b2b0", 5, 8'h00, 1'b0, 1'b0);
    check_strobe("b2b1", 6, 8'hFF, 1'b0, 1'b0);
    check_strobe("b2b2", 7, 8'h81, 1'b0, 1'b0);

    // Reset during DATA of a 4th frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy", 32'(busy), 32'h1);
    resetn = 1'b0;
    #1;
    check("mid_rst_data", 32'(data), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    wait_cycles(3);
    resetn = 1'b1;
    wait_cycles(200);
    check("mid_rst_strobes", 32'(strobe_cnt), 32'd8);

    base = strobe_cnt;
    send_frame(8'h42, 1'b0, 1'b1, 1'b0);
    wait_cycles(2);
    check("post_rst_strobes", 32'(strobe_cnt - base), 32'd1);
    check_strobe("post_rst", 8, 8'h42, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- UART receive path: the counterpart to the Tx parity generator.
- Deserialises frames of 1 start bit, 8 data bits (LSB first), 1 parity bit and 1 stop bit from the serial line.
- Checks the received parity against the selected parity type and the stop bit against the idle level.
- Presents each received byte with a one-cycle valid strobe and error flags to the host-side logic.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit period; must be >= 4 and even.
- DATA_BITS, 8, data bits per frame; fixed at 8 by the package, listed here for bench visibility.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx  in  1  serial line; idle high; asynchronous to clk
- p_type  in  1  parity type: 0 = even, 1 = odd (same encoding as Tx)
- data  out  8  last received byte
- data_valid  out  1  one-cycle strobe: data, parity_err and frame_err are valid
- parity_err  out  1  received parity bit mismatched the expected parity
- frame_err  out  1  stop bit sampled low
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is async on resetn low.
  - All outputs go to 0, FSM goes to IDLE, counters clear.
  - Both synchroniser flops reset to 1 (line idle).
  - Reset mid-frame discards the partial frame; no data_valid is issued.
- rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s, so the input-to-FSM latency is 2 cycles.
- The FSM has six states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when rx_s == 0, go to START, clear the cycle counter and latch p_type into p_type_q. A p_type change mid-frame has no effect on the frame in progress.
  - START: count CLKS_PER_BIT/2 - 1 cycles, then sample rx_s (mid-bit).
    - If 1: false start (glitch). Return to IDLE; no flags, no strobe.
    - If 0: go to DATA with bit index 0.
  - DATA: sample every CLKS_PER_BIT cycles. Shift the sample into bit[index], LSB first. After index 7 is sampled, go to PARITY.
  - PARITY: sample after CLKS_PER_BIT cycles into rx_par.
  - STOP: sample after CLKS_PER_BIT cycles.
    - On the next cycle: data is updated, data_valid = 1 for exactly one cycle, and both error flags are updated.
    - Stop bit 1: go to IDLE.
    - Stop bit 0: set frame_err = 1 and go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. A line held low (break) produces exactly one frame_err strobe, not repeated frames.
- Parity check: expected = ^byte ^ p_type_q; parity_err = rx_par != expected.
- data, parity_err and frame_err hold their values until the next data_valid. They are not cleared in between.
- Back-to-back frames: a start bit immediately after a good stop bit is accepted. IDLE is re-entered in the same cycle data_valid is asserted, so no bit time is lost.
- The cycle counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at each sample point. No overflow is possible.
- busy = (state != IDLE).

Decomposition:
- uart_pkg holds:
  - state enum rx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK)
  - localparam DATA_BITS = 8
  - parity encoding constants PAR_EVEN = 0, PAR_ODD = 1, shared with the Tx ParityGen
- One sub-module: parity_chk.
  - Combinational; inputs byte, rx_par, p_type; output err.
  - Instantiated once.
  - Its equation mirrors ParityGen, so Tx and Rx share a single parity convention.

Test Plan (CLKS_PER_BIT = 16; line driven by a bench Tx model):
- Even parity good frame: byte 0xA5 (four 1s), parity bit 0, stop 1, p_type = 0 -> one data_valid, data = 0xA5, parity_err = 0, frame_err = 0. Strobe occurs 2 + 8 + 16*10 + 1 cycles after rx falls.
- Parity error: byte 0xA5, parity bit 1, p_type = 0 -> data = 0xA5, parity_err = 1, frame_err = 0.
- Odd parity: byte 0x01, parity bit 0, p_type = 1 -> parity_err = 0. Toggle p_type to 0 in mid-frame -> result unchanged.
- False start / framing error:
  - rx pulsed low for 4 cycles -> no data_valid, busy returns to 0 within 10 cycles.
  - Frame 0x3C with stop bit 0, then line held low for 40 bit times -> exactly one data_valid with frame_err = 1. Next valid frame 0x55 -> frame_err = 0.
- Back-to-back frames and reset:
  - Frames 0x00, 0xFF, 0x81 sent with no idle gap -> three strobes with those values in order, all flags 0.
  - resetn pulsed low during DATA of a 4th frame -> outputs 0 immediately, no strobe. A following 0x42 frame is received correctly.
